// File: rtl/pam_tx_scheduler.sv
// pam_tx_scheduler: arbitrates two symbol-pair sources into whole frames for the framer.
// Frames are FRAME_PAIRS beats long and separated by GAP_CYCLES idle cycles.
// The data path is combinational, so a beat can happen in the very first XFER cycle.
// Contested grants alternate between the sources by default.
// Defining PAM_TX_SCHED_FIXED_PRIO_EN makes every contested grant go to s1 (calibration).
module pam_tx_scheduler #(
    parameter int AD_CVER_WIDTH = 12,
    parameter int FRAME_PAIRS   = 512,
    parameter int GAP_CYCLES    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [2*AD_CVER_WIDTH-1:0] s0_data,
    input  logic                       s0_valid,
    output logic                       s0_ready,
    input  logic [2*AD_CVER_WIDTH-1:0] s1_data,
    input  logic                       s1_valid,
    output logic                       s1_ready,
    output logic [2*AD_CVER_WIDTH-1:0] m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       grant_src,
    output logic                       busy,
    output logic                       frame_done,
    output logic [15:0]                frame_cnt
);
    localparam int PW = $clog2(FRAME_PAIRS) > 10 ? $clog2(FRAME_PAIRS) : 10;
    localparam logic [PW-1:0] LAST_PAIR = PW'(FRAME_PAIRS - 1);
    localparam logic [7:0] LAST_GAP = 8'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

    state_t        state;
    logic [PW-1:0] pair_cnt;
    logic [7:0]    gap_cnt;
    logic          last_src;
    logic          xfer;
    logic          beat;
    logic          contested;
    logic          pick;

    assign xfer     = state == XFER;
    assign m_valid  = xfer && (grant_src ? s1_valid : s0_valid);
    assign m_data   = xfer ? (grant_src ? s1_data : s0_data) : '0;
    assign s0_ready = xfer && !grant_src && m_ready;
    assign s1_ready = xfer && grant_src && m_ready;
    assign beat     = m_valid && m_ready;
`ifdef PAM_TX_SCHED_FIXED_PRIO_EN
    assign contested = 1'b1;
`else
    assign contested = !last_src;
`endif
    assign pick = (s0_valid && s1_valid) ? contested : s1_valid;

    // Frame sequencing: grant in IDLE, count beats in XFER, hold off requests during GAP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pair_cnt   <= '0;
            gap_cnt    <= '0;
            last_src   <= 1'b1;
            grant_src  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: if (enable && (s0_valid || s1_valid)) begin
                    state     <= XFER;
                    grant_src <= pick;
                    last_src  <= pick;
                    busy      <= 1'b1;
                end
                XFER: if (beat) begin
                    if (pair_cnt == LAST_PAIR) begin
                        pair_cnt   <= '0;
                        gap_cnt    <= '0;
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 16'd1;
                        state      <= (GAP_CYCLES == 0) ? IDLE : GAP;
                        busy       <= GAP_CYCLES != 0;
                    end else begin
                        pair_cnt <= pair_cnt + 1'b1;
                    end
                end
                GAP: if (gap_cnt == LAST_GAP) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    gap_cnt <= gap_cnt + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pam_tx_scheduler.sv
// tb_pam_tx_scheduler: randomized scoreboard bench with a frame-level reference model.
module tb_pam_tx_scheduler;
    localparam int W   = 12;
    localparam int DW  = 2 * W;
    localparam int FP  = 16;
    localparam int GAP = 3;
    localparam int MEM = 2048;
`ifdef PAM_TX_SCHED_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [DW-1:0] s0_data = '0;
    logic          s0_valid = 1'b0;
    logic          s0_ready;
    logic [DW-1:0] s1_data = '0;
    logic          s1_valid = 1'b0;
    logic          s1_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          grant_src;
    logic          busy;
    logic          frame_done;
    logic [15:0]   frame_cnt;

    logic [DW-1:0] mem0 [MEM];
    logic [DW-1:0] mem1 [MEM];
    logic [DW-1:0] expq [$];
    int p0 = 0, p1 = 0, pr = 0, pe = 0;
    int dp0 = 0, dp1 = 0, mp0 = 0, mp1 = 0;
    int total = 0, bad = 0, beats = 0, frames = 0;

    pam_tx_scheduler #(.AD_CVER_WIDTH(W), .FRAME_PAIRS(FP), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .s0_data(s0_data), .s0_valid(s0_valid), .s0_ready(s0_ready),
        .s1_data(s1_data), .s1_valid(s1_valid), .s1_ready(s1_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .grant_src(grant_src), .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Sources and sink: random valid/ready, each source walks its own data list on handshakes
    initial begin
        logic h0, h1;
        forever begin
            @(negedge clk);
            h0 = s0_valid && s0_ready;
            h1 = s1_valid && s1_ready;
            @(posedge clk);
            #1;
            if (h0) dp0++;
            if (h1) dp1++;
            s0_valid = $urandom_range(99) < p0;
            s1_valid = $urandom_range(99) < p1;
            m_ready  = $urandom_range(99) < pr;
            enable   = $urandom_range(99) < pe;
            s0_data  = mem0[dp0 % MEM];
            s1_data  = mem1[dp1 % MEM];
        end
    end

    // Reference model: frame = FP accepted pairs from one source, then GAP idle cycles
    initial begin
        int bl, gl;
        logic g, last, done, done_n, pick, sv;
        logic [15:0] cnt;
        bl = 0; gl = 0; g = 0; last = 1; done = 0; cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_busy", busy, 0);
                chk("rst_m_valid", m_valid, 0);
                chk("rst_s0_ready", s0_ready, 0);
                chk("rst_s1_ready", s1_ready, 0);
                chk("rst_frame_done", frame_done, 0);
                chk("rst_grant_src", grant_src, 0);
                chk("rst_m_data", m_data, 0);
                chk("rst_frame_cnt", frame_cnt, 0);
                bl = 0; gl = 0; g = 0; last = 1; done = 0; cnt = 0;
                expq.delete();
            end else begin
                sv = g ? s1_valid : s0_valid;
                chk("busy", busy, (bl > 0) || (gl > 0));
                chk("m_valid", m_valid, (bl > 0) && sv);
                chk("s0_ready", s0_ready, (bl > 0) && !g && m_ready);
                chk("s1_ready", s1_ready, (bl > 0) && g && m_ready);
                chk("grant_src", grant_src, g);
                chk("frame_done", frame_done, done);
                chk("frame_cnt", frame_cnt, cnt);
                if (bl == 0) chk("idle_m_data", m_data, 0);
                done_n = 0;
                if (bl > 0) begin
                    if (sv && m_ready) begin
                        if (g) begin
                            expq.push_back(mem1[mp1 % MEM]);
                            mp1++;
                        end else begin
                            expq.push_back(mem0[mp0 % MEM]);
                            mp0++;
                        end
                        bl--;
                        if (bl == 0) begin
                            gl = GAP;
                            done_n = 1;
                            cnt = cnt + 16'd1;
                            frames++;
                        end
                    end
                end else if (gl > 0) begin
                    gl--;
                end else if (enable && (s0_valid || s1_valid)) begin
                    pick = (s0_valid && s1_valid) ? (FIXED ? 1'b1 : !last) : s1_valid;
                    g = pick;
                    last = pick;
                    bl = FP;
                end
                done = done_n;
            end
        end
    end

    // Monitor: every accepted pair on the framer side must match the next expected pair
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
                beats++;
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL beat_unexpected at %0t: got %0h expected none", $time, m_data);
                end else begin
                    chk("beat_data", m_data, expq.pop_front());
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < MEM; i++) begin
            mem0[i] = DW'($urandom);
            mem1[i] = DW'($urandom);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        p0 = 100; p1 = 0; pr = 100; pe = 100;
        repeat (80) @(posedge clk);
        p1 = 100;
        repeat (120) @(posedge clk);
        p0 = 50; p1 = 50; pr = 50;
        repeat (800) @(posedge clk);
        pe = 30; p0 = 70; p1 = 70;
        repeat (600) @(posedge clk);
        pe = 100; p0 = 60; p1 = 60; pr = 60;
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(200, 20)) @(posedge clk);
            #1 rst_n = 1'b0;
            @(posedge clk);
            #1 rst_n = 1'b1;
        end
        repeat (300) @(posedge clk);
        pe = 0; p0 = 100; p1 = 100; pr = 100;
        repeat (2 * FP + GAP + 10) @(posedge clk);
        @(negedge clk);
        #2;
        chk("queue_empty", expq.size(), 0);
        chk("beats_seen", beats > 100, 1);
        chk("frames_seen", frames > 5, 1);
        chk("drained_idle", busy, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
